// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine.
//   mod_exp_state_e : top-level sequencing states.
//   mod_exp_cnt_w() : width of the phase/bit counters. Both modules size their
//                     local mod_exp_cnt_t from it ($clog2(max(w, ew) + 1)),
//                     because a package cannot be parametrised per instance.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_SQUARE,
    ST_MULT,
    ST_DONE
  } mod_exp_state_e;

  function automatic int mod_exp_cnt_w(input int width, input int exp_width);
    return $clog2(((width > exp_width) ? width : exp_width) + 1);
  endfunction

endpackage

// File: rtl/mod_exp_engine_mul.sv
// mod_mul_serial: bit-serial modular multiplier, p = a * b mod m.
// Interleaved shift-add, scanning multiplier a MSB first, one bit per cycle.
// Every step does acc = 2*acc mod m, then acc = acc + b mod m when the a bit is
// set. Each step needs only one conditional subtract, provided acc < m and
// b <= m on entry. Operands are latched on start. The product is presented
// combinationally on p during the final cycle, and done marks that cycle.
// This lets the caller launch the next multiply on the same edge, so phases
// run back to back with exactly WIDTH cycles each.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load a, b, m and begin (restarts any multiply in flight)
//   a, b, m      : multiplier, multiplicand (b <= m), modulus (m != 0)
//   done         : p holds the finished product this cycle
//   p            : product
module mod_mul_serial
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = mod_exp_cnt_w(WIDTH, WIDTH);
  typedef logic [CNT_W-1:0] mod_exp_cnt_t;

  mod_exp_cnt_t     cnt_q;
  logic [WIDTH-1:0] acc_q, a_q, b_q, m_q;
  logic [WIDTH+1:0] m_ext, dbl, dbl_red, sum;

  // One shift-add step. WIDTH+2 bits covers 2*acc and acc + b, both below 2m.
  // NOTE: always_comb assigns every output on every path, so no latch appears.
  always_comb begin
    m_ext   = {2'b00, m_q};
    dbl     = {1'b0, acc_q, 1'b0};
    dbl_red = (dbl >= m_ext) ? dbl - m_ext : dbl;
    sum     = a_q[WIDTH-1] ? dbl_red + {2'b00, b_q} : dbl_red;
    p       = (sum >= m_ext) ? WIDTH'(sum - m_ext) : WIDTH'(sum);
  end

  assign done = (cnt_q == mod_exp_cnt_t'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt_q <= '0;
    else if (start)            cnt_q <= mod_exp_cnt_t'(WIDTH);
    else if (cnt_q != '0)      cnt_q <= cnt_q - mod_exp_cnt_t'(1);
  end

  // NOTE: the datapath has no reset. It is always loaded on start before use,
  // and the counter alone decides when p is meaningful.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_q <= '0;
      a_q   <= a;
      b_q   <= b;
      m_q   <= m;
    end else if (cnt_q != '0) begin
      acc_q <= p;
      a_q   <= a_q << 1;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: result = base^exponent mod modulus, square-and-multiply,
// exponent scanned MSB first. A single mod_mul_serial instance is reused for
// each phase: REDUCE (base mod m), SQUARE and MULT.
// Optional feature macro: MODEXP_LEADING_ZERO_SKIP_EN
//   defined   : leading zero bits of the exponent are skipped.
//   undefined : all EXP_WIDTH bits are scanned.
//   Results are identical either way; only the latency differs.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   start_valid / start_ready : operand handshake (ready only in IDLE)
//   base, exponent, modulus   : operands, latched on accept
//   result, error             : qualified by result_valid;
//                               error is set when modulus == 0
//   result_valid/result_ready : result handshake, held stable until accepted
//   busy                      : REDUCE/SQUARE/MULT in progress
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 error,
  output logic                 busy
);

  localparam int CNT_W = mod_exp_cnt_w(WIDTH, EXP_WIDTH);
  typedef logic [CNT_W-1:0] mod_exp_cnt_t;

  mod_exp_state_e       state_q, state_d;
  logic [WIDTH-1:0]     r_q, b_red_q, mod_q;
  logic [EXP_WIDTH-1:0] exp_q;   // MSB is always the bit being scanned
  mod_exp_cnt_t         bits_q;  // exponent bits not yet squared
  logic                 err_q;

  logic                 mul_start, mul_done;
  logic [WIDTH-1:0]     mul_a, mul_b, mul_m, mul_p;

`ifdef MODEXP_LEADING_ZERO_SKIP_EN
  logic         exp_found;
  mod_exp_cnt_t exp_msb;

  // Priority encoder: the highest set bit wins because it is assigned last.
  always_comb begin
    exp_found = 1'b0;
    exp_msb   = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (exp_q[i]) begin
        exp_found = 1'b1;
        exp_msb   = mod_exp_cnt_t'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and multiplier launch. A phase's product on mul_p feeds the
  // next launch on the same edge, so phases follow with no idle cycles.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_a     = r_q;
    mul_b     = r_q;
    mul_m     = mod_q;
    case (state_q)
      ST_IDLE: begin
        mul_a = base;
        mul_b = WIDTH'(1);
        mul_m = modulus;
        if (start_valid) begin
          if (modulus == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_REDUCE;
            mul_start = 1'b1;
          end
        end
      end
      ST_REDUCE: begin
        if (mul_done) begin
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
          if (!exp_found) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SQUARE;
            mul_start = 1'b1;
          end
`else
          state_d   = ST_SQUARE;
          mul_start = 1'b1;
`endif
        end
      end
      ST_SQUARE: begin
        mul_a = mul_p;
        mul_b = mul_p;
        if (mul_done) begin
          if (exp_q[EXP_WIDTH-1]) begin
            state_d   = ST_MULT;
            mul_start = 1'b1;
            mul_b     = b_red_q;
          end else if (bits_q == mod_exp_cnt_t'(1)) begin
            state_d = ST_DONE;
          end else begin
            mul_start = 1'b1;
          end
        end
      end
      ST_MULT: begin
        mul_a = mul_p;
        mul_b = mul_p;
        if (mul_done) begin
          if (bits_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SQUARE;
            mul_start = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand and accumulator registers. Outputs are gated by state, so these
  // need no reset.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          mod_q  <= modulus;
          exp_q  <= exponent;
          err_q  <= (modulus == '0);
          // 1 mod m: 0 for m == 1, and 0 as the error result for m == 0.
          r_q    <= (modulus > WIDTH'(1)) ? WIDTH'(1) : '0;
          bits_q <= mod_exp_cnt_t'(EXP_WIDTH);
        end
      end
      ST_REDUCE: begin
        if (mul_done) begin
          b_red_q <= mul_p;
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
          exp_q  <= exp_q << (mod_exp_cnt_t'(EXP_WIDTH - 1) - exp_msb);
          bits_q <= exp_msb + mod_exp_cnt_t'(1);
`endif
        end
      end
      ST_SQUARE: begin
        if (mul_done) begin
          r_q    <= mul_p;
          exp_q  <= exp_q << 1;
          bits_q <= bits_q - mod_exp_cnt_t'(1);
        end
      end
      ST_MULT: begin
        if (mul_done) r_q <= mul_p;
      end
      default: ;
    endcase
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .m       (mul_m),
    .done    (mul_done),
    .p       (mul_p)
  );

  assign start_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = (state_q == ST_DONE) ? r_q : '0;
  assign error        = (state_q == ST_DONE) && err_q;
  assign busy         = (state_q == ST_REDUCE) || (state_q == ST_SQUARE) ||
                        (state_q == ST_MULT);

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at WIDTH = EXP_WIDTH = 16.
// Expected results and latencies are hand-computed. Latency is counted as in
// the design description: 1 for a result visible in the cycle right after
// the accept edge, plus one for every further edge.
module tb_mod_exp_engine;

  localparam int W  = 16;
  localparam int EW = 16;

`ifdef MODEXP_LEADING_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exponent = '0;
  logic [W-1:0]  modulus = '0;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          error;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .base         (base),
    .exponent     (exponent),
    .modulus      (modulus),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/start_ready"},  start_ready, 1);
    check({tag, "/busy"},         busy, 0);
    check({tag, "/result_valid"}, result_valid, 0);
    check({tag, "/error"},        error, 0);
    check({tag, "/result"},       result, 0);
  endtask

  // One operation: present operands, wait for the result (bounded), check
  // value/error/latency, optionally apply backpressure, then accept.
  task automatic run_op(input string tag, input logic [W-1:0] b, input logic [EW-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] exp_res,
                        input logic exp_err, input int lat_full, input int lat_skip,
                        input int hold);
    int lat;
    int exp_lat;
    exp_lat = SKIP ? lat_skip : lat_full;
    @(negedge clk);
    check({tag, "/idle_ready"}, start_ready, 1);
    base = b; exponent = e; modulus = m; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 1;
    check({tag, "/busy_after_accept"}, busy, (m != '0) ? 1 : 0);
    while (!result_valid && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/result_valid"}, result_valid, 1);
    check({tag, "/result"}, result, exp_res);
    check({tag, "/error"}, error, exp_err);
    if (exp_lat > 0) check({tag, "/latency"}, lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      start_valid = ~i[0];
      base = 16'h00AA; exponent = 16'h0003; modulus = 16'h0101;
      @(posedge clk);
      #1;
      check({tag, "/hold_valid"}, result_valid, 1);
      check({tag, "/hold_result"}, result, exp_res);
      check({tag, "/hold_start_ready"}, start_ready, 0);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, "/valid_dropped"}, result_valid, 0);
    check({tag, "/ready_again"}, start_ready, 1);
    check({tag, "/idle_not_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Main function, latencies: full scan / leading-zero skip.
    run_op("4^13%497",      16'd4,     16'd13,   16'd497,   16'd445,  1'b0, 321, 129, 0);
    run_op("65^17%3233",    16'd65,    16'd17,   16'd3233,  16'd2790, 1'b0, 305, 129, 0);
    run_op("2790^2753%3233",16'd2790,  16'd2753, 16'd3233,  16'd65,   1'b0, 353, 289, 0);
    run_op("2^10%1000",     16'd2,     16'd10,   16'd1000,  16'd24,   1'b0, 305, 113, 0);
    // Inputs not pre-reduced, near-full-width intermediates.
    run_op("500^1%497",     16'd500,   16'd1,    16'd497,   16'd3,    1'b0, 289, 49,  0);
    run_op("65535^2%65533", 16'hFFFF,  16'd2,    16'd65533, 16'd4,    1'b0, 289, 65,  0);
    // Edge cases.
    run_op("7^0%497",       16'd7,     16'd0,    16'd497,   16'd1,    1'b0, 273, 17,  0);
    run_op("5^3%1",         16'd5,     16'd3,    16'd1,     16'd0,    1'b0, 305, 81,  0);
    run_op("m0_error",      16'd9,     16'd5,    16'd0,     16'd0,    1'b1, 1,   1,   0);
    // Backpressure with ignored start pulses.
    run_op("backpressure",  16'd4,     16'd13,   16'd497,   16'd445,  1'b0, 321, 129, 20);

    // Reset in the middle of a SQUARE phase.
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (W + 5) @(posedge clk);
    #1;
    check("midreset/busy_before", busy, 1);
    check("midreset/no_valid_before", result_valid, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_reset",   16'd4,     16'd13,   16'd497,   16'd445,  1'b0, 321, 129, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_engine.md
# mod_exp_engine

Parametrised bit-serial modular exponentiator computing result = base^exponent mod modulus with valid/ready handshakes on both sides. It is the next-generation replacement for the fixed-width exponentiation path inside the RSA `control` datapath: operand widths are configurable, inputs need not be pre-reduced, and an error response is returned for an illegal modulus. Encrypt and decrypt both go through this block, using (e, n) or (d, n) respectively.

## Interface
- `WIDTH`, 128, width of base, modulus and result.
- `EXP_WIDTH`, `WIDTH`, width of exponent.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  operand set presented.
- `start_ready`  out  1  engine idle and able to accept operands.
- `base`  in  `WIDTH`  message or ciphertext; any value, including values ≥ modulus.
- `exponent`  in  `EXP_WIDTH`  e or d.
- `modulus`  in  `WIDTH`  n.
- `result`  out  `WIDTH`  base^exponent mod modulus.
- `result_valid`  out  1  `result` and `error` valid.
- `result_ready`  in  1  consumer accepts the result.
- `error`  out  1  modulus was 0; qualified by `result_valid`.
- `busy`  out  1  computation in progress.

## Operation
- States: IDLE, REDUCE, SQUARE, MULT, DONE.
- IDLE: `start_ready`=1. When `start_valid` && `start_ready`, all operands are latched.
  - If modulus==0, go to DONE with `error`=1 and `result`=0.
  - Otherwise go to REDUCE.
- Modular multiply uses interleaved shift-add over the `WIDTH` bits of multiplier a, MSB first.
  - Each step: acc = 2·acc mod m, then, if the a bit is set, acc = acc + b mod m.
  - Each conditional subtract is done once per step, with `WIDTH`+2 bit intermediates.
  - The result is always < m.
- REDUCE: b_red = mulmod(base, 1) = base mod m. r is initialised to 1 mod m, which is 0 when m==1.
- Exponent scan runs from MSB to LSB, bit index k.
  - SQUARE: r = mulmod(r, r).
  - Then, if exponent[k]=1, MULT: r = mulmod(r, b_red).
  - After bit 0, go to DONE.
- DONE: `result_valid`=1 and `result` holds r. Both remain stable until `result_ready`=1. The engine then returns to IDLE on the next edge.
- `busy`=1 in REDUCE/SQUARE/MULT. `start_ready`=1 only in IDLE. `start_valid` in any other state is ignored.
- Reset value of all outputs: `result`=0, `result_valid`=0, `error`=0, `busy`=0, `start_ready`=1.
- Assertion of `reset_n` mid-operation aborts immediately to IDLE. No partial result is ever presented.

## Timing
- Accept edge T0. REDUCE occupies cycles T0+1 … T0+`WIDTH`.
- Each SQUARE or MULT phase is exactly `WIDTH` cycles.
- Latency from accept edge to the first `result_valid` cycle is `WIDTH`·(1 + N_sq + N_mul) + 1.
  - N_sq is the number of scanned exponent bits.
  - N_mul is the number of set bits among them.
- Modulus==0: `result_valid` is asserted at T0+1.
- `result_ready` held high in DONE gives a one-cycle DONE. `start_ready` rises the following cycle.
- Back-to-back operation: minimum one IDLE cycle between results.

## Configuration
- `MODEXP_LEADING_ZERO_SKIP_EN` defined:
  - During REDUCE, a priority encoder locates the exponent MSB set bit. The scan starts there, so N_sq = position+1.
  - exponent==0 goes from REDUCE directly to DONE with r = 1 mod m.
- Undefined:
  - All `EXP_WIDTH` bits are scanned (N_sq = `EXP_WIDTH`), including leading zeros.
  - Exponent==0 also yields 1 mod m.
- Results are identical with and without the macro; only latency differs.

## Structure
- `mod_exp_pkg` holds:
  - the state enum;
  - a `mod_exp_cnt_t` counter width of $clog2(max(`WIDTH`,`EXP_WIDTH`)+1).
- Sub-module `mod_mul_serial` is the bit-serial mulmod engine, with start/done and `WIDTH`-cycle latency. The FSM reuses it for REDUCE, SQUARE and MULT.

## Test plan
All scenarios use `WIDTH`=16, `EXP_WIDTH`=16.
- base=4, exp=13, m=497 → result=445, `error`=0.
  - Latency 321 cycles without the macro (16·(1+16+3)+1).
  - Latency 129 cycles with the macro (16·(1+4+3)+1).
- RSA round trip, n=3233:
  - base=65, exp=17 → 2790.
  - Then base=2790, exp=2753 → 65.
- Reduction and edge cases:
  - base=500, exp=1, m=497 → 3.
  - exp=0, m=497 → 1.
  - m=1 → 0.
- m=0 → `result_valid` at T0+1 with `error`=1 and `result`=0.
- Backpressure: hold `result_ready`=0 for 20 cycles in DONE.
  - `result` and `result_valid` stay stable throughout.
  - `start_valid` pulses are ignored (`start_ready`=0).
- Pulse `reset_n` low midway through a SQUARE phase.
  - All outputs go to their reset values immediately.
  - The next operation (4, 13, 497) returns 445.
